// File: rtl/op_exec_unit.sv
// Execution stage: buffers decoded bundles in a small FIFO, executes them on single-cycle or
// 4-iteration datapaths, compares against the expected value and keeps saturating counters.
module op_exec_unit #(
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid_i,
    input  logic [3:0]       op_a_i,
    input  logic [3:0]       op_b_i,
    input  logic [7:0]       op_c_i,
    input  logic [3:0]       op_op_i,
    output logic             op_ready_o,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [7:0]       res_data_o,
    output logic             res_match_o,
    output logic             res_err_o,
    output logic             overflow_o,
    output logic [CNT_W-1:0] pass_cnt_o,
    output logic [CNT_W-1:0] fail_cnt_o
);
    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    localparam logic [PtrW-1:0] PtrLast = PtrW'(FIFO_DEPTH - 1);
    localparam logic [CntW-1:0] CntFull = CntW'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

    state_e            state_q, state_d;
    logic [19:0]       mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]   fifo_cnt_q, fifo_cnt_d;
    logic              overflow_q;
    logic [3:0]        a_q, b_q, op_q;
    logic [7:0]        c_q;
    logic [1:0]        iter_q, iter_d;
    logic [7:0]        acc_q, acc_d;
    logic [7:0]        res_data_q, res_data_d;
    logic              res_match_q, res_match_d, res_err_q, res_err_d;
    logic [CNT_W-1:0]  pass_q, pass_d, fail_q, fail_d;

    logic full, empty, pop, push, accept, is_multi, sc_err;
    logic [7:0] a8, b8, sc_res, mul_acc, multi_res;
    logic [4:0] div_shift, div_rem;
    logic       div_ge;

    assign full   = (fifo_cnt_q == CntFull);
    assign empty  = (fifo_cnt_q == '0);
    assign pop    = (state_q == StIdle) && !empty;
    assign push   = op_valid_i && (!full || pop);
    assign accept = (state_q == StDone) && res_ready_i;

    always_comb begin
        fifo_cnt_d = fifo_cnt_q;
        if (push && !pop)      fifo_cnt_d = fifo_cnt_q + 1'b1;
        else if (pop && !push) fifo_cnt_d = fifo_cnt_q - 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1;
            fifo_cnt_q <= fifo_cnt_d;
            if (op_valid_i && full && !pop) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {op_op_i, op_c_i, op_b_i, op_a_i};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            {op_q, c_q, b_q, a_q} <= '0;
        end else if (pop) begin
            {op_q, c_q, b_q, a_q} <= mem_q[rd_ptr_q];
        end
    end

    assign a8 = {4'b0, a_q};
    assign b8 = {4'b0, b_q};

    always_comb begin
        sc_res = 8'h00;
        sc_err = 1'b0;
        unique case (op_q)
            4'd0:    sc_res = a8 + b8;
            4'd1:    sc_res = a8 - b8;
            4'd3:    sc_res = a8 & b8;
            4'd4:    sc_res = a8 | b8;
            4'd5:    sc_res = a8 ^ b8;
            4'd6:    sc_res = a8 << b_q[2:0];
            4'd7:    sc_res = a8 >> b_q[2:0];
            4'd2, 4'd8: sc_res = 8'h00;
            default: sc_err = 1'b1;
        endcase
    end

    assign is_multi = (op_q == 4'd2) || (op_q == 4'd8);

    // MUL adds A<<i when B[i] is set; DIV keeps {remainder, quotient} in acc, MSB of A first.
    assign mul_acc   = acc_q + (b_q[iter_q] ? (a8 << iter_q) : 8'h00);
    assign div_shift = {acc_q[7:4], a_q[2'd3 - iter_q]};
    assign div_ge    = (div_shift >= {1'b0, b_q});
    assign div_rem   = div_ge ? (div_shift - {1'b0, b_q}) : div_shift;
    assign multi_res = (op_q == 4'd2) ? mul_acc :
                       (b_q == 4'd0)  ? 8'hFF   : {div_rem[3:0], acc_q[2:0], div_ge};

    always_comb begin
        state_d     = state_q;
        iter_d      = iter_q;
        acc_d       = acc_q;
        res_data_d  = res_data_q;
        res_match_d = res_match_q;
        res_err_d   = res_err_q;
        pass_d      = pass_q;
        fail_d      = fail_q;
        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    state_d = StExec;
                    iter_d  = 2'd0;
                    acc_d   = 8'h00;
                end
            end
            StExec: begin
                if (!is_multi) begin
                    res_data_d  = sc_res;
                    res_err_d   = sc_err;
                    res_match_d = (sc_res == c_q) && !sc_err;
                    state_d     = StDone;
                end else begin
                    acc_d  = (op_q == 4'd2) ? mul_acc : {div_rem[3:0], acc_q[2:0], div_ge};
                    iter_d = iter_q + 2'd1;
                    if (iter_q == 2'd3) begin
                        res_data_d  = multi_res;
                        res_err_d   = (op_q == 4'd8) && (b_q == 4'd0);
                        res_match_d = (multi_res == c_q) && !res_err_d;
                        state_d     = StDone;
                    end
                end
            end
            StDone: begin
                if (res_ready_i) begin
                    state_d = StIdle;
                    if (res_match_q && (pass_q != '1)) pass_d = pass_q + 1'b1;
                    if (!res_match_q && (fail_q != '1)) fail_d = fail_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            iter_q      <= 2'd0;
            acc_q       <= 8'h00;
            res_data_q  <= 8'h00;
            res_match_q <= 1'b0;
            res_err_q   <= 1'b0;
            pass_q      <= '0;
            fail_q      <= '0;
        end else begin
            state_q     <= state_d;
            iter_q      <= iter_d;
            acc_q       <= acc_d;
            res_data_q  <= res_data_d;
            res_match_q <= res_match_d;
            res_err_q   <= res_err_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
        end
    end

    assign op_ready_o  = !full;
    assign res_valid_o = (state_q == StDone);
    assign res_data_o  = res_data_q;
    assign res_match_o = res_match_q;
    assign res_err_o   = res_err_q;
    assign overflow_o  = overflow_q;
    assign pass_cnt_o  = pass_q;
    assign fail_cnt_o  = fail_q;

    logic unused_accept;
    assign unused_accept = accept;
endmodule

// File: tb/tb_op_exec_unit.sv
// Directed bench for op_exec_unit: datapath results, latency, FIFO overflow, reset, saturation.
module tb_op_exec_unit;
    logic        clk;
    logic        reset;
    logic        op_valid_i;
    logic [3:0]  op_a_i, op_b_i, op_op_i;
    logic [7:0]  op_c_i;
    logic        res_ready_i;
    logic        op_ready_o, res_valid_o, res_match_o, res_err_o, overflow_o;
    logic [7:0]  res_data_o;
    logic [15:0] pass_cnt_o, fail_cnt_o;
    logic        s_op_ready, s_valid, s_match, s_err, s_ovf;
    logic [7:0]  s_data;
    logic [1:0]  s_pass, s_fail;

    int total = 0;
    int bad   = 0;
    int n;
    int extra;
    logic [7:0] exp_q [3];

    op_exec_unit dut (
        .clk(clk), .reset(reset), .op_valid_i(op_valid_i), .op_a_i(op_a_i), .op_b_i(op_b_i),
        .op_c_i(op_c_i), .op_op_i(op_op_i), .op_ready_o(op_ready_o), .res_valid_o(res_valid_o),
        .res_ready_i(res_ready_i), .res_data_o(res_data_o), .res_match_o(res_match_o),
        .res_err_o(res_err_o), .overflow_o(overflow_o), .pass_cnt_o(pass_cnt_o),
        .fail_cnt_o(fail_cnt_o)
    );

    op_exec_unit #(.FIFO_DEPTH(2), .CNT_W(2)) u_sat (
        .clk(clk), .reset(reset), .op_valid_i(op_valid_i), .op_a_i(op_a_i), .op_b_i(op_b_i),
        .op_c_i(op_c_i), .op_op_i(op_op_i), .op_ready_o(s_op_ready), .res_valid_o(s_valid),
        .res_ready_i(res_ready_i), .res_data_o(s_data), .res_match_o(s_match),
        .res_err_o(s_err), .overflow_o(s_ovf), .pass_cnt_o(s_pass), .fail_cnt_o(s_fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic [7:0] c);
        @(negedge clk);
        op_valid_i = 1'b1;
        op_op_i    = op;
        op_a_i     = a;
        op_b_i     = b;
        op_c_i     = c;
    endtask

    task automatic send(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                        input logic [7:0] c);
        drive(op, a, b, c);
        @(negedge clk);
        op_valid_i = 1'b0;
    endtask

    // Counts rising edges until res_valid_o is seen, bounded.
    task automatic wait_valid(output int cnt);
        cnt = 0;
        while (!res_valid_o && cnt < 30) begin
            @(posedge clk);
            #1;
            cnt++;
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset       = 1'b0;
        op_valid_i  = 1'b0;
        op_a_i      = 4'h0;
        op_b_i      = 4'h0;
        op_c_i      = 8'h00;
        op_op_i     = 4'h0;
        res_ready_i = 1'b1;
        exp_q[0] = 8'h02;
        exp_q[1] = 8'h04;
        exp_q[2] = 8'h06;
        #1;
        chk("rst_valid", 32'(res_valid_o), 32'h0);
        chk("rst_data", 32'(res_data_o), 32'h0);
        chk("rst_match_err", 32'({res_match_o, res_err_o}), 32'h0);
        chk("rst_overflow", 32'(overflow_o), 32'h0);
        chk("rst_ready", 32'(op_ready_o), 32'h1);
        chk("rst_counts", 32'({pass_cnt_o, fail_cnt_o}), 32'h0);
        @(negedge clk);
        reset = 1'b1;

        send(4'd0, 4'd3, 4'd5, 8'h08);
        wait_valid(n);
        chk("add_latency", 32'(n), 32'd2);
        chk("add_data", 32'(res_data_o), 32'h08);
        chk("add_match_err", 32'({res_match_o, res_err_o}), 32'h2);
        @(posedge clk); #1;
        chk("add_pass_cnt", 32'(pass_cnt_o), 32'd1);
        chk("add_valid_drop", 32'(res_valid_o), 32'h0);

        send(4'd1, 4'd2, 4'd5, 8'h00);
        wait_valid(n);
        chk("sub_data", 32'(res_data_o), 32'hFD);
        chk("sub_match", 32'(res_match_o), 32'h0);
        @(posedge clk); #1;
        chk("sub_fail_cnt", 32'(fail_cnt_o), 32'd1);

        send(4'hC, 4'd1, 4'd1, 8'h00);
        wait_valid(n);
        chk("ill_data", 32'(res_data_o), 32'h00);
        chk("ill_match_err", 32'({res_match_o, res_err_o}), 32'h1);
        @(posedge clk); #1;

        send(4'd2, 4'd15, 4'd15, 8'hE1);
        wait_valid(n);
        chk("mul_latency", 32'(n), 32'd5);
        chk("mul_data", 32'(res_data_o), 32'hE1);
        chk("mul_match", 32'(res_match_o), 32'h1);
        @(posedge clk); #1;

        send(4'd8, 4'd13, 4'd4, 8'h13);
        wait_valid(n);
        chk("div_latency", 32'(n), 32'd5);
        chk("div_data", 32'(res_data_o), 32'h13);
        chk("div_match_err", 32'({res_match_o, res_err_o}), 32'h2);
        @(posedge clk); #1;

        send(4'd8, 4'd13, 4'd0, 8'hFF);
        wait_valid(n);
        chk("div0_latency", 32'(n), 32'd5);
        chk("div0_data", 32'(res_data_o), 32'hFF);
        chk("div0_match_err", 32'({res_match_o, res_err_o}), 32'h1);
        @(posedge clk); #1;
        chk("cnt_pass_6ops", 32'(pass_cnt_o), 32'd3);
        chk("cnt_fail_6ops", 32'(fail_cnt_o), 32'd3);

        // Stall the consumer and overrun the FIFO.
        @(negedge clk);
        res_ready_i = 1'b0;
        drive(4'd0, 4'd1, 4'd1, 8'h02);
        drive(4'd0, 4'd2, 4'd2, 8'h04);
        drive(4'd0, 4'd3, 4'd3, 8'h06);
        drive(4'd0, 4'd4, 4'd4, 8'h08);
        @(negedge clk);
        op_valid_i = 1'b0;
        chk("ovf_flag", 32'(overflow_o), 32'h1);
        chk("ovf_ready_low", 32'(op_ready_o), 32'h0);
        chk("stall_valid", 32'(res_valid_o), 32'h1);
        chk("stall_data", 32'(res_data_o), 32'h02);
        repeat (4) @(negedge clk);
        chk("stall_hold", 32'({res_valid_o, res_match_o, res_err_o, res_data_o}), 32'h602);
        res_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_valid(n);
            chk("drain_valid", 32'(res_valid_o), 32'h1);
            chk("drain_data", 32'(res_data_o), 32'(exp_q[i]));
            @(posedge clk); #1;
        end
        extra = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (res_valid_o) extra++;
        end
        chk("drain_no_4th", 32'(extra), 32'd0);
        chk("drain_pass_cnt", 32'(pass_cnt_o), 32'd6);
        chk("ovf_sticky", 32'(overflow_o), 32'h1);

        // Reset while MUL is on its third iteration.
        send(4'd2, 4'd15, 4'd15, 8'hE1);
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(res_valid_o), 32'h0);
        chk("mid_rst_outs", 32'({res_data_o, res_match_o, res_err_o, overflow_o}), 32'h0);
        chk("mid_rst_counts", 32'({pass_cnt_o, fail_cnt_o}), 32'h0);
        chk("mid_rst_ready", 32'(op_ready_o), 32'h1);
        @(negedge clk);
        reset = 1'b1;
        send(4'd0, 4'd1, 4'd1, 8'h02);
        wait_valid(n);
        chk("post_rst_latency", 32'(n), 32'd2);
        chk("post_rst_data", 32'(res_data_o), 32'h02);
        @(posedge clk); #1;
        chk("post_rst_pass", 32'(pass_cnt_o), 32'd1);

        // Two-bit counter instance saturates at 3.
        pulse_reset();
        for (int i = 0; i < 4; i++) begin
            send(4'd0, 4'd1, 4'd2, 8'h03);
            wait_valid(n);
            @(posedge clk); #1;
            chk("sat_pass_cnt", 32'(s_pass), (i < 3) ? 32'(i + 1) : 32'd3);
            chk("wide_pass_cnt", 32'(pass_cnt_o), 32'(i + 1));
        end
        chk("sat_fail_cnt", 32'(s_fail), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
